// File: rtl/mem_access_unit.sv
// Load/store unit: aligns pipeline requests onto a word-wide memory bus and extracts load data.
// Optional bus-ack watchdog is enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam logic [1:0] CauseOk       = 2'b00;
  localparam logic [1:0] CauseMisLoad  = 2'b01;
  localparam logic [1:0] CauseMisStore = 2'b10;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be nonzero");
  end

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  width_q, width_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cause_q, cause_d;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic        req_misaligned;
  logic [3:0]  be_w;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  always_comb begin
    unique case (req_width)
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = 1'b0;
      default: req_misaligned = |req_addr[1:0];
    endcase
  end

  // Byte-lane enables and replicated store data, derived from the registered request.
  always_comb begin
    unique case (width_q)
      2'b01: begin
        be_w       = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be_w       = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      default: begin
        be_w       = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_v;
    half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (addr_q[1:0])
      2'b00:   byte_v = mem_rdata[7:0];
      2'b01:   byte_v = mem_rdata[15:8];
      2'b10:   byte_v = mem_rdata[23:16];
      default: byte_v = mem_rdata[31:24];
    endcase
    unique case (width_q)
      2'b01:   load_data = {{16{signed_q & half[15]}}, half};
      2'b10:   load_data = {{24{signed_q & byte_v[7]}}, byte_v};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    width_d  = width_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cause_d  = cause_q;
`ifdef MAU_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d  = req_write;
          width_d  = req_width;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
`ifdef MAU_TIMEOUT_EN
          cnt_d    = '0;
`endif
          if (req_misaligned) begin
            state_d = StResp;
            rdata_d = '0;
            cause_d = req_write ? CauseMisStore : CauseMisLoad;
          end else begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        if (mem_ack) begin
          state_d = StResp;
          rdata_d = write_q ? 32'd0 : load_data;
          cause_d = CauseOk;
`ifdef MAU_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StResp;
          rdata_d = '0;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      width_q  <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cause_q  <= CauseOk;
`ifdef MAU_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      width_q  <= width_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cause_q  <= cause_d;
`ifdef MAU_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Bus fields are forced to zero whenever no request is outstanding.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = rdata_q;
    resp_cause = cause_q;
    mem_req    = (state_q == StBus);
    mem_we     = mem_req & write_q;
    mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be     = mem_req ? be_w : 4'b0000;
    mem_wdata  = mem_req ? lane_wdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit; expected responses queued at issue, checked on resp_valid.
// Timeout scenarios run only when MAU_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_width  (req_width),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_cause (resp_cause),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_resp", resp_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("resp_rdata", resp_rdata, e.rdata);
        check_eq("resp_cause", {30'd0, resp_cause}, {30'd0, e.cause});
      end
    end
  end

  function automatic logic model_mis(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b10) return 1'b0;
    if (w == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    if (w == 2'b10) return 4'b0001 << a[1:0];
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] wd);
    if (w == 2'b01) return {wd[15:0], wd[15:0]};
    if (w == 2'b10) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    return wd;
  endfunction

  function automatic logic [31:0] model_rdata(input logic wr, input logic [1:0] w, input logic sg,
                                              input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    if (wr) return 32'd0;
    if (w == 2'b01) return sg ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
    if (w == 2'b10) return sg ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
    return rd;
  endfunction

  // Starts right after a negedge; ends right after a negedge with the unit back in idle.
  task automatic do_access(input string tag, input logic wr, input logic [1:0] w, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int delay, input logic mis, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                           input logic [1:0] exp_cause);
    exp_t e;
    check_eq({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_width = w;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    e.rdata = exp_rdata;
    e.cause = exp_cause;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom;
    if (mis) begin
      check_eq({tag, "_mis_noreq"}, mem_req, 1'b0);
      check_eq({tag, "_mis_resp"}, resp_valid, 1'b1);
    end else begin
      for (int i = 0; i <= delay; i++) begin
        check_eq({tag, "_mem_req"}, mem_req, 1'b1);
        check_eq({tag, "_mem_we"}, mem_we, wr);
        check_eq({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
        check_eq({tag, "_mem_be"}, mem_be, exp_be);
        check_eq({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
        check_eq({tag, "_early_resp"}, resp_valid, 1'b0);
        mem_rdata = (i == delay) ? rd : $urandom;
        mem_ack = (i == delay);
        @(negedge clk);
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      check_eq({tag, "_resp_lat"}, resp_valid, 1'b1);
      check_eq({tag, "_req_drop"}, mem_req, 1'b0);
      check_eq({tag, "_be_idle"}, mem_be, 4'b0000);
    end
    @(negedge clk);
    check_eq({tag, "_pulse1"}, resp_valid, 1'b0);
    check_eq({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
    check_eq({tag, "_hold_cause"}, resp_cause, exp_cause);
    check_eq({tag, "_ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_width = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_cause", resp_cause, 2'b00);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_be", mem_be, 4'b0000);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_access("wload", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0,
              4'b1111, 32'h0, 32'hDEADBEEF, 2'b00);
    do_access("sbload", 1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, 1'b0,
              4'b1000, 32'h0, 32'hFFFFFF80, 2'b00);
    do_access("ubload", 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h80112233, 1, 1'b0,
              4'b1000, 32'h0, 32'h00000080, 2'b00);
    do_access("hstore", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'hFFFFFFFF, 2, 1'b0,
              4'b1100, 32'hABCDABCD, 32'h0, 2'b00);
    do_access("shload", 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'h1234F00D, 0, 1'b0,
              4'b0011, 32'h0, 32'hFFFFF00D, 2'b00);
    do_access("wstore_mis", 1'b1, 2'b00, 1'b0, 32'h06, 32'h55, 32'h0, 0, 1'b1,
              4'b0000, 32'h0, 32'h0, 2'b10);
    do_access("hload_mis", 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 32'h0, 0, 1'b1,
              4'b0000, 32'h0, 32'h0, 2'b01);
    do_access("w11load", 1'b0, 2'b11, 1'b0, 32'h302, 32'h0, 32'h0, 0, 1'b1,
              4'b0000, 32'h0, 32'h0, 2'b01);

    // Ack and req_valid while not in the matching state must be ignored.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("stray_ack_resp", resp_valid, 1'b0);
    check_eq("stray_ack_req", mem_req, 1'b0);

    for (int k = 0; k < 10; k++) begin
      logic        wr, sg, mis;
      logic [1:0]  w;
      logic [31:0] a, wd, rd;
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      w = 2'($urandom_range(0, 3));
      a = $urandom & 32'h0000_0FFF;
      wd = $urandom;
      rd = $urandom;
      mis = model_mis(w, a);
      do_access("rnd", wr, w, sg, a, wd, rd, int'($urandom_range(0, 3)), mis,
                model_be(w, a), model_wdata(w, wd),
                mis ? 32'd0 : model_rdata(wr, w, sg, a, rd),
                mis ? (wr ? 2'b10 : 2'b01) : 2'b00);
    end

    // Reset during BUS abandons the transaction.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_width = 2'b00;
    req_addr = 32'h400;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rstbus_in_bus", mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstbus_mem_req", mem_req, 1'b0);
    check_eq("rstbus_ready", req_ready, 1'b1);
    check_eq("rstbus_resp", resp_valid, 1'b0);
    check_eq("rstbus_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("rstbus_no_resp", resp_valid, 1'b0);
    @(negedge clk);

`ifdef MAU_TIMEOUT_EN
    begin
      exp_t e;
      int   n;
      e.rdata = 32'd0;
      e.cause = 2'b11;
      sb.push_back(e);
      req_valid = 1'b1;
      req_addr = 32'h40;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (mem_req && n < 20) begin
        n++;
        @(negedge clk);
      end
      check_eq("to_req_cycles", n, 4);
      check_eq("to_resp", resp_valid, 1'b1);
      @(negedge clk);
      check_eq("to_hold_cause", resp_cause, 2'b11);
    end
    do_access("to_ackwins", 1'b0, 2'b00, 1'b0, 32'h80, 32'h0, 32'hCAFE0001, 3, 1'b0,
              4'b1111, 32'h0, 32'hCAFE0001, 2'b00);
`endif

    repeat (2) @(negedge clk);
    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 64, meaning bus-ack watchdog limit in cycles (used only with MAU_TIMEOUT_EN).
REQ-002 The module SHALL have the following ports, in this order:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  pipeline presents a load/store.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_width  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- req_signed  in  1  sign-extend load result.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extracted, extended load data.
- resp_cause  out  2  00 ok, 01 misaligned load, 10 misaligned store, 11 bus timeout.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accepted/completed the request.
- mem_rdata  in  32  memory read word.

Function
REQ-003 The FSM SHALL have states IDLE, BUS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE, when req_valid is 1, the unit SHALL register the request; if aligned, next state BUS, else next state RESP with resp_cause 01 (load) or 10 (store) and no mem_req.
REQ-005 Misaligned SHALL mean: half with addr[0]=1, or word with addr[1:0]!=0; byte accesses are never misaligned.
REQ-006 In BUS, mem_req SHALL be 1 and mem_we/mem_addr/mem_be/mem_wdata SHALL be stable until the cycle mem_ack is sampled 1.
REQ-007 mem_be SHALL be: word 1111; half 1100 if addr[1] else 0011; byte 0001 shifted left by addr[1:0].
REQ-008 mem_wdata SHALL be: word wdata; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-009 On mem_ack in BUS, the unit SHALL go to RESP and latch resp_rdata: word mem_rdata; half lane addr[1] (1 = [31:16]); byte lane addr[1:0] (3 = [31:24]); zero- or sign-extended per req_signed; stores SHALL latch 0.
REQ-010 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-011 Latency: request accepted at edge N means mem_req is high in cycle N+1; mem_ack sampled at edge M means resp_valid is high in cycle M+1; a misaligned request gives resp_valid in cycle N+1.
REQ-012 resp_rdata and resp_cause SHALL hold their values until the next RESP.
REQ-013 mem_ack outside BUS SHALL be ignored; req_valid outside IDLE SHALL be ignored.
REQ-014 mem_we, mem_addr, mem_be and mem_wdata SHALL be 0 whenever mem_req is 0.

Reset
REQ-015 On reset, the state SHALL be IDLE, and all outputs except req_ready (1) SHALL be 0, including the watchdog count.
REQ-016 Reset asserted in BUS or RESP SHALL abandon the transaction: mem_req SHALL be 0 and no resp_valid pulse SHALL occur for it.

Configuration
REQ-017 With MAU_TIMEOUT_EN defined, a counter SHALL clear on entry to BUS and increment each BUS cycle without mem_ack; on reaching TIMEOUT, the FSM SHALL go to RESP with resp_cause 11 and resp_rdata 0, and drop mem_req.
REQ-018 Without MAU_TIMEOUT_EN, no counter SHALL exist and BUS SHALL wait for mem_ack indefinitely; resp_cause 11 SHALL never be produced.
REQ-019 mem_ack and the timeout in the same cycle SHALL complete normally (mem_ack wins).

Verification
REQ-020 Word load addr 0x100, mem_rdata 0xDEADBEEF, ack after 3 cycles -> mem_be 1111, mem_addr 0x100, resp_rdata 0xDEADBEEF, resp_cause 00, resp_valid 1 cycle after ack.
REQ-021 Signed byte load addr 0x103, mem_rdata 0x80112233 -> mem_be 1000, resp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-022 Half store addr 0x22, wdata 0x1234ABCD -> mem_addr 0x20, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1.
REQ-023 Word store addr 0x06 -> no mem_req, resp_valid next cycle with resp_cause 10; half load addr 0x05 -> resp_cause 01.
REQ-024 With MAU_TIMEOUT_EN and TIMEOUT=4, mem_ack held 0 -> mem_req for 4 cycles, then resp_cause 11; reset pulsed in BUS -> mem_req 0 next cycle, no resp_valid, req_ready 1.
